// File: rtl/serial_subtractor32.sv
// 32-bit subtractor that walks one nibble per cycle; result valid 8 cycles after acceptance.
// Result is held in DONE until ready_i; no new request is taken until the FSM is back in IDLE.
module serial_subtractor32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        borrow_i,
    output logic [31:0] diff_o,
    output logic        borrow_o,
    output logic        overflow_o,
    output logic        zero_o,
    output logic        valid_o,
    input  logic        ready_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] diff_q, diff_d;
    logic        borrow_q, borrow_d;
    logic        overflow_q, overflow_d;
    logic        zero_q, zero_d;

    logic [4:0]  nib_sel;
    logic [4:0]  nib_res;
    logic [31:0] diff_upd;

    always_comb begin
        nib_sel  = {cnt_q, 2'b00};
        // bit 4 of the 5-bit difference is the nibble's borrow-out
        nib_res  = {1'b0, a_q[nib_sel +: 4]} - {1'b0, b_q[nib_sel +: 4]} - {4'b0000, borrow_q};
        diff_upd = diff_q;
        diff_upd[nib_sel +: 4] = nib_res[3:0];

        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    borrow_d = borrow_i;
                    diff_d   = 32'h0;
                    cnt_d    = 3'd0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_d   = diff_upd;
                borrow_d = nib_res[4];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    // flags are captured once, from the completed difference
                    overflow_d = (a_q[31] != b_q[31]) && (diff_upd[31] != a_q[31]);
                    zero_d     = (diff_upd == 32'h0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            diff_q     <= 32'h0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign diff_o     = diff_q;
    assign borrow_o   = borrow_q;
    assign overflow_o = overflow_q;
    assign zero_o     = zero_q;

endmodule

// File: tb/tb_serial_subtractor32.sv
// Bench for serial_subtractor32: transaction-level reference model plus directed literal cases.
module tb_serial_subtractor32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] a_i = 32'h0;
    logic [31:0] b_i = 32'h0;
    logic        borrow_i = 1'b0;
    logic [31:0] diff_o;
    logic        borrow_o;
    logic        overflow_o;
    logic        zero_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    serial_subtractor32 dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .borrow_i   (borrow_i),
        .diff_o     (diff_o),
        .borrow_o   (borrow_o),
        .overflow_o (overflow_o),
        .zero_o     (zero_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
    } op_t;

    op_t q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  n_acc = 0;
    int  n_done = 0;
    int  n_issued = 0;
    int  n_aborted = 0;
    int  cyc = 0;
    int  acc_edge = 0;
    bit  pending = 1'b0;

    initial forever #5 clk_i = ~clk_i;
    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic on the accepted operands, one transaction in flight.
    initial begin
        op_t         e;
        logic [32:0] full;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                pending = 1'b0;
                q.delete();
            end else begin
                chk("ready_o_phase", {31'b0, ready_o}, {31'b0, !pending});
                chk("valid_o_phase", {31'b0, valid_o}, {31'b0, pending && (cyc >= acc_edge + 8)});
                if (valid_o && q.size() > 0) begin
                    e    = q[0];
                    full = {1'b0, e.a} - {1'b0, e.b} - {32'b0, e.bin};
                    chk("model_diff", diff_o, full[31:0]);
                    chk("model_borrow", {31'b0, borrow_o}, {31'b0, full[32]});
                    chk("model_ovf", {31'b0, overflow_o},
                        {31'b0, (e.a[31] != e.b[31]) && (full[31] != e.a[31])});
                    chk("model_zero", {31'b0, zero_o}, {31'b0, full[31:0] == 32'h0});
                    if (ready_i) begin
                        void'(q.pop_front());
                        n_done++;
                        pending = 1'b0;
                    end
                end
                if (ready_o && valid_i) begin
                    q.push_back('{a_i, b_i, borrow_i});
                    n_acc++;
                    pending  = 1'b1;
                    acc_edge = cyc + 1;
                end
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input int stall, input bit lit, input logic [31:0] ed,
                         input logic eb, input logic eo, input logic ez);
        int n;
        a_i = a; b_i = b; borrow_i = bin; valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("ready_before_req", {31'b0, ready_o}, 32'd1);
        n_issued++;
        @(posedge clk_i); #1;
        n = 0;
        while (!valid_o && n < 20) begin
            valid_i  = 1'($urandom_range(0, 1));
            a_i      = $urandom;
            b_i      = $urandom;
            borrow_i = 1'($urandom_range(0, 1));
            ready_i  = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
            n++;
        end
        ready_i = 1'b0;
        chk("latency", n, 32'd8);
        if (lit) begin
            chk("lit_diff", diff_o, ed);
            chk("lit_borrow", {31'b0, borrow_o}, {31'b0, eb});
            chk("lit_ovf", {31'b0, overflow_o}, {31'b0, eo});
            chk("lit_zero", {31'b0, zero_o}, {31'b0, ez});
        end
        repeat (stall) begin
            valid_i = 1'($urandom_range(0, 1));
            a_i     = $urandom;
            b_i     = $urandom;
            @(posedge clk_i); #1;
        end
        if (lit) begin
            chk("held_diff", diff_o, ed);
            chk("held_valid", {31'b0, valid_o}, 32'd1);
        end
        ready_i = 1'b1;
        valid_i = 1'($urandom_range(0, 1));
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        valid_i = 1'b0;
        chk("idle_after_ack", {31'b0, ready_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rbin;
        #1;
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_diff", diff_o, 32'd0);
        chk("rst_flags", {29'b0, borrow_o, overflow_o, zero_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        do_op(32'h0000000A, 32'h00000003, 1'b0, 5, 1'b1, 32'h00000007, 1'b0, 1'b0, 1'b0);
        do_op(32'h00000000, 32'h00000001, 1'b0, 0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        do_op(32'h80000000, 32'h00000001, 1'b0, 2, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        do_op(32'h12345678, 32'h12345677, 1'b1, 1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);

        // Abort an operation part-way through the nibble walk.
        a_i = 32'h89ABCDEF; b_i = 32'h01234567; borrow_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        n_issued++;
        n_aborted++;
        repeat (5) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        chk("abort_ready", {31'b0, ready_o}, 32'd1);
        chk("abort_valid", {31'b0, valid_o}, 32'd0);
        chk("abort_diff", diff_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 3, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 6000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rbin = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = ra - {31'b0, rbin};
                1: ra = 32'h80000000;
                2: rb = 32'h7FFFFFFF;
                default: ;
            endcase
            do_op(ra, rb, rbin, $urandom_range(0, 2), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("accepted_count", n_acc, n_issued);
        chk("completed_count", n_done, n_issued - n_aborted);
        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
